bhg_line_fetch: RTL
===================

# bhg_line_fetch

Line-fetch sequencer upstream of the video pattern generator's dual line buffer, running in the CMD_CLK domain. It tracks the generator's active-video enables and, one line ahead of display, issues burst read requests to the DDR3 read port. It writes the returned 128-bit words into the idle half of the 2×512-word line buffer and flips the displayed-line select at each line end. It also reports underruns when a line has not fully arrived in time.

## Interface
- BASE_ADDR, 0: byte address of line 0 of the frame.
- LINE_STRIDE, 8192: byte distance between consecutive frame lines.
- WORDS_PER_LINE, 480: 128-bit words per line (1920 px × 32 bit); legal 1..512.
- V_LINES, 1080: lines per frame.
- MAX_INFLIGHT, 16: max accepted-but-unreturned reads; legal 1..63.
- ADDR_WIDTH, 29: read address width.

- CMD_CLK  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  permits starting a new frame.
- CMD_xena_in  in  1  active-line enable from generator (CMD_CLK domain).
- CMD_yena_in  in  1  active-frame enable from generator (CMD_CLK domain).
- x_scroll_in  in  2  pixel offset, latched per frame.
- rd_req  out  1  read request.
- rd_ready  in  1  request accepted when rd_req && rd_ready.
- rd_addr  out  ADDR_WIDTH  byte address of the requested 16-byte word.
- rd_valid  in  1  returned word valid; returns arrive in request order, no backpressure.
- rd_data  in  128  returned word.
- CMD_xpos_out  out  2  to generator CMD_xpos_in.
- CMD_ypos_out  out  1  to generator CMD_ypos_in: buffer half to display.
- CMD_line_mem_wena  out  1  line-buffer write enable.
- CMD_line_mem_waddr  out  10  {half, word[8:0]}.
- CMD_line_mem_wdata  out  128  line-buffer data.
- busy  out  1  high in any state other than IDLE/DONE.
- underrun  out  1  sticky; cleared only by reset.

## Operation
- Edge detect: xena_d/yena_d registered, both reset to 0. yfall = yena_d & !CMD_yena_in. xfall = xena_d & !CMD_xena_in.
- States: IDLE, FETCH, WAIT, DONE, DRAIN.
- Frame start, on yfall in any state:
  - If inflight≠0: go to DRAIN. Returns arriving in DRAIN are discarded (wena held 0).
  - Otherwise, or on leaving DRAIN when inflight=0: if enable=1, set line=0, fill half=0, CMD_ypos_out=0, latch CMD_xpos_out=x_scroll_in, line_base=BASE_ADDR, and enter FETCH. If enable=0, enter IDLE.
- FETCH:
  - rd_req=1 while req_cnt<WORDS_PER_LINE and inflight<MAX_INFLIGHT.
  - rd_addr = line_base + 16·req_cnt, truncated to ADDR_WIDTH.
  - Each accepted request increments req_cnt and inflight. Each rd_valid decrements inflight, writes {fill half, wr_cnt} and increments wr_cnt.
  - When wr_cnt==WORDS_PER_LINE, go to WAIT.
- WAIT: on xfall, set CMD_ypos_out=fill half. If line+1<V_LINES: fill half toggles, line++, line_base+=LINE_STRIDE, req_cnt=wr_cnt=0, enter FETCH. Otherwise enter DONE.
- xfall while in FETCH (late line):
  - Set underrun=1. No toggle: the generator repeats the previous line.
  - Fetch continues. On completion go to WAIT and flip at the next xfall.
- Line 0 prefetch completes during vblank. The first active line displays half 0, and line 1 fills half 1 during it.
- Simultaneous yfall and xfall: yfall wins.
- Simultaneous request accept and rd_valid: inflight unchanged.

## Timing
- Reset values: rd_req=0, rd_addr=0, CMD_xpos_out=0, CMD_ypos_out=0, CMD_line_mem_wena=0, CMD_line_mem_waddr=0, CMD_line_mem_wdata=0, busy=0, underrun=0. State=IDLE and all counters 0.
- rd_req asserts the cycle after FETCH entry. Back-to-back requests are allowed at one per cycle.
- rd_valid at cycle n produces registered wena, waddr and wdata at cycle n+1.
- CMD_ypos_out changes the cycle after the xfall sample. The generator samples it at its next H-sync.
- Reset assertion mid-operation forces reset values immediately. Returns still in flight after reset release are ignored because inflight=0 and the state is IDLE.

## Test plan
- Reset, then WORDS_PER_LINE=4, V_LINES=3, BASE_ADDR=0x1000, LINE_STRIDE=0x100, rd_ready=1, latency 5. On yfall: requests at 0x1000, 0x1010, 0x1020, 0x1030; writes to waddr 0..3; state WAIT; CMD_ypos_out=0.
- Continue the same frame with three xfalls. Line 1 lands at waddr 512..515 from 0x1100; CMD_ypos_out sequence is 0→1→0; line 2 comes from 0x1200; state DONE after the third xfall.
- MAX_INFLIGHT=2 with return latency 10: never more than 2 accepted-unreturned requests; all 4 words are still written in order.
- Hold rd_ready=0 past the first active xfall: underrun=1, CMD_ypos_out does not toggle on that xfall and toggles on the next.
- yfall with 3 reads in flight: state DRAIN, wena stays 0 for the 3 returns, then line 0 prefetch restarts at BASE_ADDR.
- yfall and xfall in the same cycle while in WAIT: frame restart occurs (line=0, CMD_ypos_out=0) and no toggle.

Source files
------------

// File: rtl/bhg_line_fetch.sv
`default_nettype none
// =============================================================================
// bhg_line_fetch : line-ahead DDR3 burst fetch into the dual video line buffer
// Revision       : 1.0
// =============================================================================
module bhg_line_fetch #(
  parameter int unsigned ADDR_WIDTH     = 29,
  parameter int unsigned BASE_ADDR      = 0,
  parameter int unsigned LINE_STRIDE    = 8192,
  parameter int unsigned WORDS_PER_LINE = 480,
  parameter int unsigned V_LINES        = 1080,
  parameter int unsigned MAX_INFLIGHT   = 16
) (
  input  logic                  CMD_CLK,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  CMD_xena_in,
  input  logic                  CMD_yena_in,
  input  logic [1:0]            x_scroll_in,
  output logic                  rd_req,
  input  logic                  rd_ready,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rd_valid,
  input  logic [127:0]          rd_data,
  output logic [1:0]            CMD_xpos_out,
  output logic                  CMD_ypos_out,
  output logic                  CMD_line_mem_wena,
  output logic [9:0]            CMD_line_mem_waddr,
  output logic [127:0]          CMD_line_mem_wdata,
  output logic                  busy,
  output logic                  underrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  xena_q, yena_q;
  logic [15:0]           line_q, line_d;
  logic                  half_q, half_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [9:0]            req_cnt_q, req_cnt_d;
  logic [9:0]            wr_cnt_q, wr_cnt_d;
  logic [6:0]            inflight_q, inflight_d;
  logic                  rd_req_q, rd_req_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]            xpos_q, xpos_d;
  logic                  ypos_q, ypos_d;
  logic                  wena_q, wena_d;
  logic [9:0]            waddr_q, waddr_d;
  logic [127:0]          wdata_q, wdata_d;
  logic                  busy_q, busy_d;
  logic                  underrun_q, underrun_d;

  logic yfall, xfall, accept, ret, restart;

  assign yfall  = yena_q & ~CMD_yena_in;
  assign xfall  = xena_q & ~CMD_xena_in;
  assign accept = rd_req_q & rd_ready;
  // With nothing outstanding a return is stale (e.g. issued before reset) and is dropped.
  assign ret    = rd_valid & (inflight_q != 7'd0);

  always_comb begin
    state_d    = state_q;
    line_d     = line_q;
    half_d     = half_q;
    base_d     = base_q;
    req_cnt_d  = req_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_addr_d  = rd_addr_q;
    xpos_d     = xpos_q;
    ypos_d     = ypos_q;
    wena_d     = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    underrun_d = underrun_q;
    restart    = 1'b0;

    inflight_d = inflight_q + {6'd0, accept} - {6'd0, ret};
    if (accept) req_cnt_d = req_cnt_q + 10'd1;

    if (ret && (state_q == S_FETCH) && !yfall) begin
      wena_d   = 1'b1;
      waddr_d  = {half_q, wr_cnt_q[8:0]};
      wdata_d  = rd_data;
      wr_cnt_d = wr_cnt_q + 10'd1;
    end

    if (yfall) begin
      if (inflight_d != 7'd0) state_d = S_DRAIN;
      else                    restart = 1'b1;
    end else begin
      case (state_q)
        S_DRAIN: if (inflight_d == 7'd0) restart = 1'b1;
        S_FETCH: begin
          if (xfall) underrun_d = 1'b1;
          if (32'(wr_cnt_d) == WORDS_PER_LINE) state_d = S_WAIT;
        end
        S_WAIT: if (xfall) begin
          ypos_d = half_q;
          if (32'(line_q) + 32'd1 < V_LINES) begin
            half_d    = ~half_q;
            line_d    = line_q + 16'd1;
            base_d    = base_q + ADDR_WIDTH'(LINE_STRIDE);
            req_cnt_d = 10'd0;
            wr_cnt_d  = 10'd0;
            state_d   = S_FETCH;
          end else begin
            state_d = S_DONE;
          end
        end
        default: ;
      endcase
    end

    if (restart) begin
      if (enable) begin
        state_d   = S_FETCH;
        line_d    = 16'd0;
        half_d    = 1'b0;
        ypos_d    = 1'b0;
        xpos_d    = x_scroll_in;
        base_d    = ADDR_WIDTH'(BASE_ADDR);
        req_cnt_d = 10'd0;
        wr_cnt_d  = 10'd0;
      end else begin
        state_d = S_IDLE;
      end
    end

    // Request outputs are registered, so they are derived from next-cycle counters.
    rd_req_d = (state_d == S_FETCH) && (32'(req_cnt_d) < WORDS_PER_LINE) &&
               (32'(inflight_d) < MAX_INFLIGHT);
    if (state_d == S_FETCH) rd_addr_d = base_d + ADDR_WIDTH'({req_cnt_d, 4'b0000});
    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
  end

  always_ff @(posedge CMD_CLK or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      xena_q     <= 1'b0;
      yena_q     <= 1'b0;
      line_q     <= 16'd0;
      half_q     <= 1'b0;
      base_q     <= '0;
      req_cnt_q  <= 10'd0;
      wr_cnt_q   <= 10'd0;
      inflight_q <= 7'd0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      xpos_q     <= 2'd0;
      ypos_q     <= 1'b0;
      wena_q     <= 1'b0;
      waddr_q    <= 10'd0;
      wdata_q    <= 128'd0;
      busy_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      xena_q     <= CMD_xena_in;
      yena_q     <= CMD_yena_in;
      line_q     <= line_d;
      half_q     <= half_d;
      base_q     <= base_d;
      req_cnt_q  <= req_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      inflight_q <= inflight_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      xpos_q     <= xpos_d;
      ypos_q     <= ypos_d;
      wena_q     <= wena_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      underrun_q <= underrun_d;
    end
  end

  assign rd_req             = rd_req_q;
  assign rd_addr            = rd_addr_q;
  assign CMD_xpos_out       = xpos_q;
  assign CMD_ypos_out       = ypos_q;
  assign CMD_line_mem_wena  = wena_q;
  assign CMD_line_mem_waddr = waddr_q;
  assign CMD_line_mem_wdata = wdata_q;
  assign busy               = busy_q;
  assign underrun           = underrun_q;

endmodule
`default_nettype wire
